cordic_stage_reg: RTL

- Parametrised elastic pipeline register for one CORDIC iteration boundary: carries N_CH data channels (default x, y, angle) with a valid/ready handshake in place of a bare enable.
- Adds a global stall (reg_en), a synchronous flush, and an optional skid buffer, so in_ready has no combinational path from out_ready.
- One instance is placed between each pair of CORDIC micro-rotation stages.

---
 rtl/cordic_pkg.sv | 19 +
 rtl/cordic_beat_reg.sv | 37 +++
 rtl/cordic_stage_reg.sv | 103 ++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// Shared CORDIC datapath definitions: default channel widths and the beat layout
// carried between micro-rotation stages and their stage registers.
package cordic_pkg;

    localparam int CORDIC_DW = 16;
    localparam int CORDIC_AW = 16;

    typedef struct packed {
        logic signed [CORDIC_DW-1:0] x;
        logic signed [CORDIC_DW-1:0] y;
        logic signed [CORDIC_AW-1:0] angle;
    } cordic_beat_t;

    // Flat width of one beat as stored in a stage register.
    function automatic int beat_w(input int dw, input int aw);
        return 2 * dw + aw;
    endfunction

endpackage

// File: rtl/cordic_beat_reg.sv
// Width-generic beat register with a valid flag: load sets it, drop clears it,
// clr discards synchronously without touching the data.
module cordic_beat_reg
    import cordic_pkg::*;
#(
    parameter int W = beat_w(CORDIC_DW, CORDIC_AW)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic         drop,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         vld
);

    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= 1'b0;
            q   <= '0;
        end else begin
            // clr wins over a same-cycle load so a beat accepted during flush is lost.
            if (clr) begin
                vld <= 1'b0;
            end else if (load) begin
                vld <= 1'b1;
            end else if (drop) begin
                vld <= 1'b0;
            end
            if (load && !clr) begin
                q <= d;
            end
        end
    end

endmodule

// File: rtl/cordic_stage_reg.sv
// Elastic valid/ready register between two CORDIC micro-rotation stages, with stall,
// flush and optional skid entry. Define CORDIC_REG_PERF_EN to add the xfer_cnt port.
module cordic_stage_reg
    import cordic_pkg::*;
#(
    parameter int DW   = CORDIC_DW,
    parameter int AW   = CORDIC_AW,
    parameter int SKID = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 reg_en,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] x,
    input  logic signed [DW-1:0] y,
    input  logic signed [AW-1:0] angle,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] x_out,
    output logic signed [DW-1:0] y_out,
    output logic signed [AW-1:0] angle_out
`ifdef CORDIC_REG_PERF_EN
    ,
    output logic [15:0]          xfer_cnt
`endif
);

    localparam int BW = beat_w(DW, AW);

    logic [BW-1:0] in_beat_p0;
    logic [BW-1:0] main_d_p0;
    logic [BW-1:0] main_beat_p1;
    logic          main_vld_p1;
    logic          main_load;
    logic          main_drop;
    logic          accept;
    logic          emit;

    assign in_beat_p0 = {x, y, angle};
    assign accept     = in_valid & in_ready;
    assign emit       = out_valid & out_ready;

    // stage p0 -> p1: outputs come straight from main, forced quiet during rst and stall
    assign out_valid                  = ~rst & reg_en & main_vld_p1;
    assign {x_out, y_out, angle_out}  = rst ? '0 : main_beat_p1;
    assign main_drop                  = emit;

    cordic_beat_reg #(.W(BW)) u_main (
        .clk  (clk),
        .rst  (rst),
        .clr  (flush),
        .load (main_load),
        .drop (main_drop),
        .d    (main_d_p0),
        .q    (main_beat_p1),
        .vld  (main_vld_p1)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic [BW-1:0] skid_beat_p1;
            logic          skid_vld_p1;
            logic          skid_load;
            logic          skid_drop;

            // Ready is purely registered: a full skid entry is the only reason to refuse.
            assign in_ready  = ~rst & reg_en & ~skid_vld_p1;
            assign main_load = (emit & skid_vld_p1) | (accept & (~main_vld_p1 | emit));
            assign main_d_p0 = skid_vld_p1 ? skid_beat_p1 : in_beat_p0;
            assign skid_load = accept & main_vld_p1 & ~emit;
            assign skid_drop = emit & skid_vld_p1;

            cordic_beat_reg #(.W(BW)) u_skid (
                .clk  (clk),
                .rst  (rst),
                .clr  (flush),
                .load (skid_load),
                .drop (skid_drop),
                .d    (in_beat_p0),
                .q    (skid_beat_p1),
                .vld  (skid_vld_p1)
            );
        end else begin : g_noskid
            assign in_ready  = ~rst & reg_en & (~main_vld_p1 | out_ready);
            assign main_load = accept;
            assign main_d_p0 = in_beat_p0;
        end
    endgenerate

`ifdef CORDIC_REG_PERF_EN
    // emit is already gated by reg_en, so the count freezes during a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_cnt <= '0;
        end else if (emit) begin
            xfer_cnt <= xfer_cnt + 16'd1;
        end
    end
`endif

endmodule
